combo_lock_ctrl: RTL and testbench
==================================

Name: combo_lock_ctrl

Overview:
Sequencing controller for the combination-lock datapath. It takes debounced single-cycle button pulses and the current 4-bit digit from the up/down digit selector. It collects a 4-digit entry, compares it against the stored code, and drives the unlock and alarm flags. It also sources the four nibbles for the seven-segment driver and issues a clear pulse that returns the digit selector to 0 after each accepted digit.

Parameters:
CODE, 16'h1234, unlock code; nibble [15:12] is the first digit entered, [3:0] the last.
MAX_TRIES, 3, consecutive wrong entries that trigger lockout; legal range 1..15.
LOCKOUT_CYCLES, 100_000_000, clk cycles spent in LOCKOUT; minimum 2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
enter  input  1  debounced one-cycle pulse; accept current digit (ENTRY) / relock (OPEN)
digit_in  input  4  current digit from the up/down selector, 0..9 expected, 0..F accepted
sel_clr  output  1  one-cycle pulse requesting the digit selector to reset to 0
disp3  output  4  leftmost display nibble
disp2  output  4  display nibble
disp1  output  4  display nibble
disp0  output  4  rightmost display nibble
unlocked  output  1  high while in OPEN
alarm  output  1  high while in LOCKOUT
fail_cnt  output  4  consecutive wrong entries since last success/reset

Behaviour:
- Reset (rst=1 at clk edge): state=ENTRY, idx=0, entry register=16'h0000, fail_cnt=0, lockout counter=0, sel_clr=0, unlocked=0, alarm=0, disp3..0=0. rst has priority over every other input.
- All outputs are registered.
- States: ENTRY, CHECK, OPEN, LOCKOUT.
- ENTRY:
  - On enter, write digit_in into entry nibble idx (idx 0 → [15:12]) and pulse sel_clr for exactly one cycle on the next cycle.
  - idx increments; when idx was 3, go to CHECK and set idx to 0.
  - enter is ignored when it is not a pulse-aligned event in ENTRY/OPEN; it is never queued.
- CHECK: one cycle.
  - If entry==CODE: go to OPEN, fail_cnt←0.
  - Else if fail_cnt+1 == MAX_TRIES: go to LOCKOUT, fail_cnt←fail_cnt+1, load lockout counter with LOCKOUT_CYCLES-1.
  - Else: go to ENTRY, fail_cnt←fail_cnt+1.
  - Every CHECK exit clears the entry register to 0.
  - Latency from the 4th enter pulse to unlocked=1 is 2 cycles: state reg, then CHECK result.
- OPEN:
  - unlocked=1.
  - On enter, go to ENTRY; unlocked falls the following cycle and sel_clr pulses once.
- LOCKOUT:
  - alarm=1; the counter decrements each cycle and enter is ignored.
  - At counter==0, go to ENTRY, fail_cnt←0, alarm←0, sel_clr pulse.
- fail_cnt saturates at 15.
- Display:
  - ENTRY: already-entered positions show stored nibbles, position idx shows live digit_in (registered, 1-cycle lag), later positions show 0.
  - CHECK: display holds.
  - OPEN: all four nibbles show 4'hA.
  - LOCKOUT: all four nibbles show 4'hF.
- Simultaneous enter and sel_clr feedback: a digit_in change caused by sel_clr never affects the nibble already captured.

Optional Feature:
COMBO_LOCK_PROGRAM_EN — adds input prog (1-bit debounced pulse) and state PROG.
- With the macro defined:
  - prog in OPEN enters PROG with idx=0 and the display cleared to 0.
  - The next four enter pulses capture a new code into a code register, with sel_clr pulses as in ENTRY.
  - After the 4th digit, the new code replaces the compare value and the block goes to ENTRY (locked).
  - rst restores the code register to CODE.
  - prog is ignored in all states except OPEN; enter in PROG never relocks.
- Without the macro: no prog port, and the compare value is the constant CODE.

Test Plan:
- rst, then enter ×4 with digit_in 1,2,3,4 (CODE=16'h1234) → unlocked=1 two cycles after 4th enter, disp=A,A,A,A, fail_cnt=0, four sel_clr pulses.
- Enter 1,2,3,5 → back in ENTRY, unlocked=0, fail_cnt=1, disp=0,0,0,0; then correct code → unlocked=1, fail_cnt=0.
- MAX_TRIES=3, LOCKOUT_CYCLES=20: three wrong codes → alarm=1, disp=F,F,F,F; enter pulses during lockout ignored; alarm=0 exactly 20 cycles after entering LOCKOUT, fail_cnt=0.
- In OPEN pulse enter → unlocked=0 next cycle, state ENTRY, idx=0; assert rst after 2 digits entered → all outputs 0, next correct 4-digit code unlocks.
- Partial entry: digit_in changes 0→7 with no enter → disp3 follows 7 one cycle later; enter → disp3 frozen at 7, disp2 tracks digit_in.
- COMBO_LOCK_PROGRAM_EN: unlock, prog, enter 9,8,7,6 → locked; 1,2,3,4 fails (fail_cnt=1); 9,8,7,6 unlocks; rst → 1,2,3,4 unlocks again.

Source files
------------

// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: 4-digit combination lock sequencer with unlock, lockout and display sourcing
// Ports: clk, rst (sync, active-high); enter (digit accept / relock pulse), digit_in[3:0] (live selector digit);
//   sel_clr (one-cycle selector clear), disp3..disp0 (display nibbles, disp3 leftmost),
//   unlocked (high in OPEN), alarm (high in LOCKOUT), fail_cnt[3:0] (consecutive wrong entries).
// Optional: define COMBO_LOCK_PROGRAM_EN to add the prog pulse input and the PROG state for runtime code change.
module combo_lock_ctrl #(
  parameter logic [15:0] CODE = 16'h1234,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic [3:0] digit_in,
`ifdef COMBO_LOCK_PROGRAM_EN
  input  logic       prog,
`endif
  output logic       sel_clr,
  output logic [3:0] disp3,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [3:0] disp0,
  output logic       unlocked,
  output logic       alarm,
  output logic [3:0] fail_cnt
);
  localparam int CW = $clog2(LOCKOUT_CYCLES);
  typedef enum logic [2:0] {ENTRY, CHECK, OPEN, LOCKOUT, PROG} stateT;
  stateT state, stateNext;
  logic [1:0] idx, idxNext;
  logic [15:0] entry, entryNext, disp, dispNext, cmpCode, live;
  logic [3:0] failNext, failInc;
  logic [CW-1:0] lockCnt, lockNext;
  logic clrNext;
`ifdef COMBO_LOCK_PROGRAM_EN
  logic [15:0] codeReg, codeNext;
  assign cmpCode = codeReg;
`else
  assign cmpCode = CODE;
`endif
  assign {disp3, disp2, disp1, disp0} = disp;
  always_comb begin
    stateNext = state;
    idxNext = idx;
    entryNext = entry;
    failNext = fail_cnt;
    lockNext = lockCnt;
    clrNext = 1'b0;
`ifdef COMBO_LOCK_PROGRAM_EN
    codeNext = codeReg;
`endif
    failInc = fail_cnt == 4'hF ? 4'hF : fail_cnt + 4'd1;
    case (state)
      ENTRY, PROG: if (enter) begin
        // idx 0 is the leftmost nibble; digit_in is sampled here, so a later sel_clr-driven change cannot touch it
        entryNext[15 - 4 * int'(idx) -: 4] = digit_in;
        idxNext = idx + 2'd1;
        clrNext = 1'b1;
        if (idx == 2'd3) begin
          stateNext = state == PROG ? ENTRY : CHECK;
          if (state == PROG) begin
`ifdef COMBO_LOCK_PROGRAM_EN
            codeNext = entryNext;
`endif
            entryNext = 16'h0;
          end
        end
      end
      CHECK: begin
        entryNext = 16'h0;
        if (entry == cmpCode) begin
          stateNext = OPEN;
          failNext = 4'd0;
        end else if ({1'b0, fail_cnt} + 5'd1 == 5'(MAX_TRIES)) begin
          stateNext = LOCKOUT;
          failNext = failInc;
          lockNext = CW'(LOCKOUT_CYCLES - 1);
        end else begin
          stateNext = ENTRY;
          failNext = failInc;
        end
      end
      OPEN:
`ifdef COMBO_LOCK_PROGRAM_EN
        if (prog) begin
          stateNext = PROG;
          idxNext = 2'd0;
        end else
`endif
        if (enter) begin
          stateNext = ENTRY;
          clrNext = 1'b1;
        end
      LOCKOUT: if (lockCnt == '0) begin
        stateNext = ENTRY;
        failNext = 4'd0;
        clrNext = 1'b1;
      end else lockNext = lockCnt - CW'(1);
      default: stateNext = ENTRY;
    endcase
    // positions past idx are always zero in the entry register, so OR-ing in the live digit is safe
    live = entryNext | (16'(digit_in) << (12 - 4 * int'(idxNext)));
    dispNext = stateNext == OPEN ? 16'hAAAA :
               stateNext == LOCKOUT ? 16'hFFFF :
               stateNext == CHECK ? entryNext :
               (stateNext == PROG && state == OPEN) ? 16'h0 : live;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ENTRY;
      idx <= 2'd0;
      entry <= 16'h0;
      fail_cnt <= 4'd0;
      lockCnt <= '0;
      sel_clr <= 1'b0;
      unlocked <= 1'b0;
      alarm <= 1'b0;
      disp <= 16'h0;
`ifdef COMBO_LOCK_PROGRAM_EN
      codeReg <= CODE;
`endif
    end else begin
      state <= stateNext;
      idx <= idxNext;
      entry <= entryNext;
      fail_cnt <= failNext;
      lockCnt <= lockNext;
      sel_clr <= clrNext;
      unlocked <= stateNext == OPEN;
      alarm <= stateNext == LOCKOUT;
      disp <= dispNext;
`ifdef COMBO_LOCK_PROGRAM_EN
      codeReg <= codeNext;
`endif
    end
  end
endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb_combo_lock_ctrl: scoreboard bench for combo_lock_ctrl; expected output changes queued by stimulus, popped by a monitor
module tb_combo_lock_ctrl;
  localparam int MAXT = 3;
  localparam int LCYC = 20;
  logic clk = 1'b0, rst = 1'b1, enter = 1'b0;
  logic [3:0] digit_in = 4'd0;
`ifdef COMBO_LOCK_PROGRAM_EN
  logic prog = 1'b0;
`endif
  logic sel_clr, unlocked, alarm;
  logic [3:0] disp3, disp2, disp1, disp0, fail_cnt;
  combo_lock_ctrl #(.CODE(16'h1234), .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LCYC)) dut (
    .clk(clk), .rst(rst), .enter(enter), .digit_in(digit_in),
`ifdef COMBO_LOCK_PROGRAM_EN
    .prog(prog),
`endif
    .sel_clr(sel_clr), .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
    .unlocked(unlocked), .alarm(alarm), .fail_cnt(fail_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {string name; logic [22:0] vec; int cyc;} expT;
  expT q[$];
  int cyc = 0, checks = 0, errors = 0;
  bit monOn = 1'b0;
  logic [22:0] prevVec;
  logic [15:0] shown = 16'h0, curCode = 16'h1234;
  logic [3:0] expFail = 4'd0;
  wire [22:0] outVec = {sel_clr, unlocked, alarm, fail_cnt, disp3, disp2, disp1, disp0};
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [22:0] mk(input bit s, input bit u, input bit a, input logic [3:0] f, input logic [15:0] d);
    return {s, u, a, f, d};
  endfunction
  task automatic push(input string n, input logic [22:0] v, input int dc);
    q.push_back('{n, v, cyc + dc});
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (monOn && outVec !== prevVec) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected: got %h at cycle %0d, required no change", outVec, cyc);
      end else begin
        expT e;
        e = q.pop_front();
        if (outVec !== e.vec || cyc != e.cyc) begin
          errors++;
          $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d", e.name, outVec, cyc, e.vec, e.cyc);
        end
      end
      prevVec = outVec;
    end
  end
  task automatic enterDigit(input int i, input logic [3:0] d, input bit prg);
    shown[15 - 4 * i -: 4] = d;
    if (i < 3) begin
      push("digit", mk(1, 0, 0, expFail, shown | (16'(d) << (12 - 4 * (i + 1)))), 1);
      push("digitClr", mk(0, 0, 0, expFail, shown), 2);
    end else if (prg) begin
      push("progLast", mk(1, 0, 0, expFail, {d, 12'h0}), 1);
      push("progDone", mk(0, 0, 0, expFail, 16'h0), 2);
      curCode = shown;
    end else begin
      push("check", mk(1, 0, 0, expFail, shown), 1);
      if (shown == curCode) begin
        expFail = 4'd0;
        push("open", mk(0, 1, 0, 4'd0, 16'hAAAA), 2);
      end else begin
        expFail = expFail == 4'hF ? 4'hF : expFail + 4'd1;
        if (expFail == MAXT) begin
          push("lockout", mk(0, 0, 1, expFail, 16'hFFFF), 2);
          push("lockExit", mk(1, 0, 0, 4'd0, 16'h0), 2 + LCYC);
          push("lockExitClr", mk(0, 0, 0, 4'd0, 16'h0), 3 + LCYC);
          expFail = 4'd0;
        end else push("wrong", mk(0, 0, 0, expFail, 16'h0), 2);
      end
    end
    if (i == 3) shown = 16'h0;
    digit_in = d;
    enter = 1'b1;
    tick;
    enter = 1'b0;
    digit_in = 4'd0;
    tick;
  endtask
  task automatic enterCode(input logic [15:0] c);
    for (int i = 0; i < 4; i++) enterDigit(i, c[15 - 4 * i -: 4], 1'b0);
  endtask
  task automatic relock;
    push("relock", mk(1, 0, 0, expFail, 16'h0), 1);
    push("relockClr", mk(0, 0, 0, expFail, 16'h0), 2);
    enter = 1'b1;
    tick;
    enter = 1'b0;
    tick;
  endtask
  task automatic doReset;
    push("reset", 23'h0, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    expFail = 4'd0;
    shown = 16'h0;
  endtask
  initial begin
    tick;
    tick;
    checks++;
    if (outVec !== 23'h0) begin
      errors++;
      $display("FAIL resetState: got %h, required %h", outVec, 23'h0);
    end
    prevVec = outVec;
    monOn = 1'b1;
    rst = 1'b0;
    tick;
    enterCode(16'h1234);
    relock;
    enterCode(16'h1235);
    enterCode(16'h1234);
    relock;
    enterCode(16'h4321);
    enterDigit(0, 4'd1, 1'b0);
    enterDigit(1, 4'd2, 1'b0);
    doReset;
    tick;
    enterCode(16'h1234);
    relock;
    digit_in = 4'd7;
    push("live7", mk(0, 0, 0, expFail, 16'h7000), 1);
    tick;
    tick;
    push("cap7", mk(1, 0, 0, expFail, 16'h7700), 1);
    push("track3", mk(0, 0, 0, expFail, 16'h7300), 2);
    enter = 1'b1;
    tick;
    enter = 1'b0;
    digit_in = 4'd3;
    tick;
    push("track0", mk(0, 0, 0, expFail, 16'h7000), 1);
    digit_in = 4'd0;
    tick;
    shown = 16'h7000;
    enterDigit(1, 4'd0, 1'b0);
    enterDigit(2, 4'd0, 1'b0);
    enterDigit(3, 4'd1, 1'b0);
    enterCode(16'h0000);
    enterCode(16'h5555);
    tick;
    enter = 1'b1;
    digit_in = 4'd9;
    tick;
    enter = 1'b0;
    digit_in = 4'd0;
    repeat (LCYC + 3) tick;
`ifdef COMBO_LOCK_PROGRAM_EN
    enterCode(16'h1234);
    push("prog", mk(0, 0, 0, expFail, 16'h0), 1);
    prog = 1'b1;
    tick;
    prog = 1'b0;
    enterDigit(0, 4'd9, 1'b1);
    enterDigit(1, 4'd8, 1'b1);
    enterDigit(2, 4'd7, 1'b1);
    enterDigit(3, 4'd6, 1'b1);
    enterCode(16'h1234);
    enterCode(16'h9876);
    doReset;
    curCode = 16'h1234;
    tick;
    enterCode(16'h1234);
    relock;
`endif
    repeat (3) tick;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending events (next %s), required 0", q.size(), q[0].name);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
